// File: rtl/lock_pkg.sv
// Shared types and defaults for the parametrised digit-lock controller.
// No logic; constants only. Build option LOCK_AUTO_RELOCK_EN uses RELOCK_CYC_DEF.
// No flow control; all consumers are single-cycle pulse driven.
package lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } lock_state_t;

    localparam int unsigned PW_LEN_DEF      = 4;
    localparam int unsigned DIGIT_W_DEF     = 2;
    localparam int unsigned MAX_FAIL_DEF    = 3;
    localparam int unsigned LOCKOUT_CYC_DEF = 250000000;
    localparam int unsigned RELOCK_CYC_DEF  = 500000000;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high whenever the count sits at zero.
// Latency: load takes effect next cycle; each run cycle subtracts one, saturating at zero.
// Backpressure: none; load has priority over run.
module lock_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/lock_fsm_param.sv
// Digit-code lock: entry buffer, stored code, compare, failure lockout (option LOCK_AUTO_RELOCK_EN adds idle relock).
// Latency: submit pulse at cycle N yields correct_pw/incorrect_pw and new state at N+2.
// Backpressure: none; button pulses arriving in CHECK or LOCKOUT are dropped.
module lock_fsm_param
    import lock_pkg::*;
#(
    parameter int unsigned PW_LEN      = PW_LEN_DEF,
    parameter int unsigned DIGIT_W     = DIGIT_W_DEF,
    parameter int unsigned MAX_FAIL    = MAX_FAIL_DEF,
    parameter int unsigned LOCKOUT_CYC = LOCKOUT_CYC_DEF
`ifdef LOCK_AUTO_RELOCK_EN
    ,
    parameter int unsigned RELOCK_CYC  = RELOCK_CYC_DEF
`endif
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          input_btn,
    input  logic                          submit_btn,
    input  logic                          store_btn,
    input  logic                          clear_btn,
    output logic                          unlocked,
    output logic                          locked_out,
    output logic                          correct_pw,
    output logic                          incorrect_pw,
    output logic [$clog2(PW_LEN+1)-1:0]   entry_cnt,
    output logic [PW_LEN*DIGIT_W-1:0]     entry_digits,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int unsigned CW = $clog2(PW_LEN + 1);
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
`ifdef LOCK_AUTO_RELOCK_EN
    localparam int unsigned TMAX = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC - 1 : RELOCK_CYC - 1;
`else
    localparam int unsigned TMAX = LOCKOUT_CYC - 1;
`endif
    localparam int unsigned TW = cnt_w(TMAX);

    typedef logic [0:PW_LEN-1][DIGIT_W-1:0] code_t;

    lock_state_t   state_q, state_d;
    code_t         ent_q, ent_d, ent_app, code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d, fail_inc;
    logic          cpw_q, cpw_d, ipw_q, ipw_d;
    logic          tmr_load, tmr_run, tmr_done;
    logic [TW-1:0] tmr_val;
    logic          full, match;

    assign full     = (cnt_q == CW'(PW_LEN));
    assign match    = full && (ent_q == code_q);
    assign fail_inc = fail_q + FW'(1);

    // Buffer with digit_in written at the next free slot; only used when not full.
    always_comb begin
        ent_app = ent_q;
        for (int i = 0; i < int'(PW_LEN); i++) begin
            if (cnt_q == CW'(i)) begin
                ent_app[i] = digit_in;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ent_d    = ent_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        fail_d   = fail_q;
        cpw_d    = 1'b0;
        ipw_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TW'(LOCKOUT_CYC - 1);

        case (state_q)
            LOCKED: begin
                if (clear_btn) begin
                    ent_d = '0;
                    cnt_d = '0;
                end else if (submit_btn) begin
                    state_d = CHECK;
                end else if (store_btn) begin
                    state_d = LOCKED;
                end else if (input_btn && !full) begin
                    ent_d = ent_app;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                ent_d = '0;
                cnt_d = '0;
                if (match) begin
                    cpw_d   = 1'b1;
                    fail_d  = '0;
                    state_d = UNLOCKED;
`ifdef LOCK_AUTO_RELOCK_EN
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RELOCK_CYC - 1);
`endif
                end else begin
                    ipw_d  = 1'b1;
                    fail_d = fail_inc;
                    if (fail_inc == FW'(MAX_FAIL)) begin
                        state_d  = LOCKOUT;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            UNLOCKED: begin
                if (clear_btn) begin
                    ent_d = '0;
                    cnt_d = '0;
                end else if (submit_btn) begin
                    ent_d   = '0;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end else if (store_btn) begin
                    if (full) begin
                        code_d = ent_q;
                        ent_d  = '0;
                        cnt_d  = '0;
                    end
                end else if (input_btn && !full) begin
                    ent_d = ent_app;
                    cnt_d = cnt_q + CW'(1);
                end
`ifdef LOCK_AUTO_RELOCK_EN
                // Any pulse restarts the idle window; silence until expiry relocks.
                if (clear_btn || submit_btn || store_btn || input_btn) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RELOCK_CYC - 1);
                end else if (tmr_done) begin
                    ent_d   = '0;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
`endif
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    fail_d  = '0;
                    state_d = LOCKED;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

`ifdef LOCK_AUTO_RELOCK_EN
    assign tmr_run = (state_q == LOCKOUT) || (state_q == UNLOCKED);
`else
    assign tmr_run = (state_q == LOCKOUT);
`endif

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LOCKED;
            ent_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            fail_q  <= '0;
            cpw_q   <= 1'b0;
            ipw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            fail_q  <= fail_d;
            cpw_q   <= cpw_d;
            ipw_q   <= ipw_d;
        end
    end

    assign unlocked     = (state_q == UNLOCKED);
    assign locked_out   = (state_q == LOCKOUT);
    assign correct_pw   = cpw_q;
    assign incorrect_pw = ipw_q;
    assign entry_cnt    = cnt_q;
    assign entry_digits = ent_q;
    assign fail_cnt     = fail_q;

endmodule

// File: doc/lock_fsm_param.md
Name: lock_fsm_param

Overview:
- Parametrised successor to the fixed 4-character lock controller/checker pair: one block holds the stored code, collects entered digits, compares, and enforces a timed lockout after repeated failures.
- Sits between button edge-detect logic (single-cycle pulses) and the HEX display/LED drivers.
- Generalises code length and digit width.
- Adds failure counting, lockout timing and a change-code mode.

Parameters:
- PW_LEN, 4, digits per code (>=1)
- DIGIT_W, 2, bits per digit (1..4)
- MAX_FAIL, 3, consecutive failed submits that trigger lockout (>=1)
- LOCKOUT_CYC, 250000000, lockout duration in clk cycles (>=2)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- digit_in  in  DIGIT_W  digit value from switches
- input_btn  in  1  one-cycle pulse: append digit_in to entry buffer
- submit_btn  in  1  one-cycle pulse: compare (LOCKED) or relock (UNLOCKED)
- store_btn  in  1  one-cycle pulse: save entry as new code (UNLOCKED only)
- clear_btn  in  1  one-cycle pulse: empty entry buffer
- unlocked  out  1  high while in UNLOCKED
- locked_out  out  1  high while in LOCKOUT
- correct_pw  out  1  one-cycle pulse on successful compare
- incorrect_pw  out  1  one-cycle pulse on failed compare
- entry_cnt  out  $clog2(PW_LEN+1)  digits currently entered
- entry_digits  out  PW_LEN*DIGIT_W  entry buffer; digit 0 (first entered) in MSBs
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- Reset (async assert, sync release):
  - State LOCKED.
  - Stored code all zeros.
  - Entry buffer, entry_cnt and fail_cnt all 0.
  - All outputs 0.
- States: LOCKED, CHECK, UNLOCKED, LOCKOUT.
- Button priority, when several pulses land in one cycle: clear > submit > store > input. Only the winner acts.
- input_btn in LOCKED/UNLOCKED:
  - If entry_cnt < PW_LEN, digit_in is written at position entry_cnt and entry_cnt increments.
  - At entry_cnt == PW_LEN the digit is ignored; no wrap, no shift.
- clear_btn: entry buffer and entry_cnt go to 0 next cycle, in any state except LOCKOUT.
- LOCKED + submit_btn: go to CHECK. Compare is registered and takes 1 cycle.
- CHECK:
  - Match means entry_cnt == PW_LEN and buffer == stored code.
  - On match: pulse correct_pw, set fail_cnt to 0, go to UNLOCKED.
  - Otherwise: pulse incorrect_pw and increment fail_cnt.
    - If the new fail_cnt == MAX_FAIL, go to LOCKOUT; else go to LOCKED.
  - Either way the entry buffer is cleared.
  - All buttons are ignored while in CHECK.
  - Latency: submit pulse at cycle N gives the result pulse and the new state at cycle N+2.
- UNLOCKED:
  - store_btn with entry_cnt == PW_LEN: copies the buffer to the stored code and clears the buffer; stays UNLOCKED.
  - store_btn with entry_cnt < PW_LEN: ignored; stored code unchanged.
  - submit_btn: clears the buffer and goes to LOCKED.
- LOCKOUT:
  - A counter loads LOCKOUT_CYC-1 on entry and decrements each cycle. At 0 the block goes to LOCKED and fail_cnt is set to 0.
  - All buttons are ignored, including clear.
  - locked_out is high for exactly LOCKOUT_CYC cycles.
- store_btn in LOCKED is ignored.
- Reset mid-operation (any state, including mid-lockout) returns everything to the reset values. The stored code is not preserved.
- correct_pw and incorrect_pw are never high together and are never high for two consecutive cycles.

Optional Feature:
- Macro: LOCK_AUTO_RELOCK_EN.
- Defined:
  - Adds parameter RELOCK_CYC (default 500000000).
  - UNLOCKED with no button pulse for RELOCK_CYC consecutive cycles returns to LOCKED and clears the buffer.
  - Any button pulse restarts the idle count.
  - The idle counter shares the lockout counter.
- Undefined: UNLOCKED persists until submit_btn or reset, and no extra logic is present.

Decomposition:
- Package lock_pkg holds:
  - the state enum (LOCKED, CHECK, UNLOCKED, LOCKOUT);
  - the default constants for PW_LEN, DIGIT_W, MAX_FAIL, LOCKOUT_CYC and RELOCK_CYC;
  - a helper width function for the counters.
- One sub-module, lock_timer: a loadable down-counter with clk, resetn, load, load_val, run and done.
  - Used for the lockout period and, with LOCK_AUTO_RELOCK_EN, the auto-relock period.
  - Replaces the old free-standing sleep divider.

Test Plan:
- PW_LEN=4, DIGIT_W=2, MAX_FAIL=3, LOCKOUT_CYC=20.
- Reset, enter 0,0,0,0, submit:
  - correct_pw pulses 2 cycles after submit; unlocked=1; fail_cnt=0.
- While unlocked, enter 3,1,2,0, then store, then submit (relock). Enter 3,1,2,0, submit:
  - unlocked=1.
  - With entry 3,1,2,1 instead: incorrect_pw pulses and fail_cnt=1.
- Three wrong submits:
  - fail_cnt reaches 3 and locked_out=1 for exactly 20 cycles.
  - input_btn pulses during lockout leave entry_cnt=0.
  - Afterwards state is LOCKED with fail_cnt=0.
- Five input pulses, then submit with the correct code:
  - entry_cnt saturates at 4 and the 5th digit is dropped; unlock succeeds.
  - A submit with only 3 digits gives incorrect_pw.
- Simultaneous clear_btn and submit_btn in LOCKED:
  - buffer is cleared; no correct_pw or incorrect_pw pulse; state stays LOCKED.
- Assert resetn=0 mid-lockout (cycle 10):
  - locked_out=0 immediately (asynchronously); stored code reverts to 0000.
  - With LOCK_AUTO_RELOCK_EN and RELOCK_CYC=30: after unlocking and staying idle, the block relocks after 30 cycles.
